score_tally: RTL and testbench
==============================

Name: score_tally

Overview:
- Collects judgement results from the arrow-lane droppers and turns them into game score.
- Each dropper raises a hit level and a finish level when its arrow resolves. This block edge-detects both, classifies each lane event as hit or miss, and keeps a saturating BCD score, a combo counter, and hit/miss counts.
- Its outputs drive the score/combo text renderer and the hit/miss flash overlay.
- It shares the droppers' keycode round control: space starts a round, 8'h01 returns to idle.

Parameters:
- NUM_LANES, 4, number of dropper lanes.
- BONUS_AT, 10, combo value at or above which a hit is worth 2 points instead of 1.
- FLASH_FRAMES, 15, number of frames the hit/miss flash is held.
- KEY_START, 8'h2c, keycode that starts a round.
- KEY_CLEAR, 8'h01, keycode that returns the block to idle.

Ports:
- frame_clk  in  1  frame clock, one tick per video frame.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  8  primary USB keycode.
- score_lvl  in  NUM_LANES  per-lane hit level from the dropper. High from the resolving frame until that dropper is re-armed.
- done_lvl  in  NUM_LANES  per-lane finished level from the dropper. High while that dropper is in its End state.
- score_bcd  out  16  four BCD digits, digit 3 most significant.
- combo  out  8  current consecutive-hit count.
- max_combo  out  8  best combo reached this round.
- hits  out  8  hit count.
- misses  out  8  miss count.
- flash_hit  out  1  hit flash active.
- flash_miss  out  1  miss flash active.
- playing  out  1  high while in state PLAY.
- game_over  out  1  high while in state OVER.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - FSM goes to IDLE.
  - score_bcd, combo, max_combo, hits, misses, the flash timer, the done_seen mask and both prev-edge registers all go to 0.
  - All outputs are 0.
- Edge detect:
  - prev_score and prev_done register score_lvl and done_lvl on every frame_clk, in all states.
  - A level that is already high on entry to PLAY is never counted.
- Event classification, per lane, in PLAY only:
  - The lane event is a rising edge of done_lvl.
  - It is a hit if score_lvl is high in that same cycle. Otherwise it is a miss.
  - A score_lvl rise without a done_lvl rise is ignored.
- Simultaneous lanes:
  - nh = popcount(hit events) and nm = popcount(miss events) in the cycle.
  - hits += nh and misses += nm, each saturating at 255.
- Points:
  - Each hit is worth 2 if combo (the value before this cycle) >= BONUS_AT, else 1.
  - The cycle adds nh * value, range 0..8, into score_bcd as a decimal add with carry.
  - The result saturates at 9999; the score never wraps.
- Combo:
  - If nm > 0, combo is set to 0, even if the same cycle also has hits.
  - Else combo += nh, saturating at 255.
  - max_combo is updated to the registered combo result when that result is larger.
- Flash:
  - An event cycle loads the flash timer with FLASH_FRAMES.
  - flash_miss is set if nm > 0; otherwise flash_hit is set. Miss takes priority.
  - The timer decrements once per frame and both flags clear when it reaches 0.
  - A new event reloads the timer.
- done_seen:
  - The done_seen mask ORs in the lanes that had an event this cycle.
- FSM:
  - IDLE: on keycode == KEY_START, clear score_bcd, combo, max_combo, hits, misses, done_seen and the flash state, then go to PLAY next cycle.
  - PLAY:
    - Process events each cycle.
    - Go to OVER when done_seen including the current cycle's events is all ones.
    - The last events are fully accounted before the state becomes OVER.
    - keycode == KEY_CLEAR goes to IDLE without clearing counters; the events of that cycle are still processed.
  - OVER:
    - Counters are frozen and events are ignored.
    - The flash timer keeps counting down.
    - keycode == KEY_CLEAR goes to IDLE.
- Latency: an event is visible on the outputs at the first frame_clk edge after the rising edge of done_lvl is sampled, i.e. one register stage.
- Output flags: playing = (state == PLAY), game_over = (state == OVER).
- Reset asserted mid-round: everything is cleared immediately; there is no partial update.

Decomposition:
- Package tally_pkg holds:
  - state enum {IDLE, PLAY, OVER};
  - the keycode constants KEY_START and KEY_CLEAR;
  - a function for a 4-bit popcount.
- Sub-module bcd_add_sat: 16-bit BCD score plus a 4-bit binary addend (0..8) gives a 16-bit BCD result, combinational, saturating at 9999.

Test Plan:
- Single hit: start with 8'h2c; raise done_lvl[0] and score_lvl[0] in the same frame → next frame score_bcd=16'h0001, combo=1, hits=1, flash_hit=1.
- Miss breaks combo: 3 hits, then done_lvl[2] rises with score_lvl[2]=0 → combo=0, max_combo=3, misses=1, flash_miss=1. After 15 frames with no events, flash_miss=0.
- Bonus and simultaneous events:
  - Preload combo=9 via hits, then 2 lanes hit in the same cycle → each worth 1 point (combo 9 < 10), score +2, combo=11.
  - Next hit → score +2.
  - A cycle with 1 hit and 1 miss → combo=0, hits+1, misses+1, flash_miss.
- BCD carry and saturation:
  - From score 0x0099, one hit → 0x0100.
  - From 0x9998, two bonus hits in one cycle → 0x9999, held there.
- Round end: all 4 lanes resolve over several frames → game_over rises in the frame after the 4th event. Further edges do not change counters. 8'h01 → IDLE. 8'h2c → counters cleared.
- Stale level and reset:
  - done_lvl[1] high before 8'h2c and held high after → no event counted.
  - Assert Reset_n low mid-PLAY → all outputs 0 immediately, without waiting for frame_clk.

Source files
------------

// File: rtl/score_tally_pkg.sv
// tally_pkg: shared types, constants and helpers for the score_tally block.
package tally_pkg;

   localparam int         NUM_LANES    = 4;
   localparam int         BONUS_AT     = 10;
   localparam logic [3:0] FLASH_FRAMES = 4'd15;
   localparam logic [7:0] KEY_START    = 8'h2c;
   localparam logic [7:0] KEY_CLEAR    = 8'h01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   // Internal state made visible for checkers and bring-up.
   typedef struct packed {
      state_t                 state;
      logic [NUM_LANES-1:0]   done_seen;
      logic [NUM_LANES-1:0]   prev_done;
      logic [NUM_LANES-1:0]   prev_score;
      logic [3:0]             flash_timer;
   } dbg_t;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/score_tally_if.sv
// score_tally_if: dropper levels and keycode in, score/overlay state out.
// Bus semantics: there is no valid/ready handshake. Every input is a level
// sampled on each frame_clk edge; every output is registered state that
// changes only on that edge (or immediately on reset).
interface score_tally_if;
   import tally_pkg::*;

   logic [7:0]           keycode;
   logic [NUM_LANES-1:0] score_lvl;
   logic [NUM_LANES-1:0] done_lvl;

   logic [15:0]          score_bcd;
   logic [7:0]           combo;
   logic [7:0]           max_combo;
   logic [7:0]           hits;
   logic [7:0]           misses;
   logic                 flash_hit;
   logic                 flash_miss;
   logic                 playing;
   logic                 game_over;

   modport master (
      output keycode, score_lvl, done_lvl,
      input  score_bcd, combo, max_combo, hits, misses,
             flash_hit, flash_miss, playing, game_over
   );

   modport slave (
      input  keycode, score_lvl, done_lvl,
      output score_bcd, combo, max_combo, hits, misses,
             flash_hit, flash_miss, playing, game_over
   );
endinterface

// File: rtl/score_tally_bcd_add_sat.sv
// bcd_add_sat: four-digit BCD value plus a small binary addend, clamped at 9999.
module bcd_add_sat
   import tally_pkg::*;
(
   input  logic [15:0] i_bcd,
   input  logic [3:0]  i_addend,
   output logic [15:0] o_bcd
);

   logic [4:0]  w_carry;
   logic [4:0]  w_sum;
   logic [15:0] w_res;

   // Ripple a decimal add across the digits; a carry out of digit 3 means overflow.
   always_comb begin
      w_carry = {1'b0, i_addend};
      w_sum   = 5'd0;
      w_res   = 16'd0;
      for (int i = 0; i < 4; i++) begin
         w_sum = {1'b0, i_bcd[4*i +: 4]} + w_carry;
         if (w_sum > 5'd9) begin
            w_res[4*i +: 4] = 4'(w_sum - 5'd10);
            w_carry         = 5'd1;
         end else begin
            w_res[4*i +: 4] = w_sum[3:0];
            w_carry         = 5'd0;
         end
      end
      o_bcd = (w_carry != 5'd0) ? 16'h9999 : w_res;
   end

endmodule

// File: rtl/score_tally.sv
// score_tally: turns dropper hit/finish levels into score, combo, counts and flash.
module score_tally
   import tally_pkg::*;
(
   input  logic         frame_clk,
   input  logic         Reset_n,
   score_tally_if.slave bus,
   output dbg_t         o_dbg
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [NUM_LANES-1:0] r_prev_score;
   logic [NUM_LANES-1:0] r_prev_done;
   logic [NUM_LANES-1:0] r_done_seen;
   logic [15:0]          r_score;
   logic [7:0]           r_combo;
   logic [7:0]           r_max_combo;
   logic [7:0]           r_hits;
   logic [7:0]           r_misses;
   logic [3:0]           r_flash_timer;
   logic                 r_flash_hit;
   logic                 r_flash_miss;

   logic                 w_process;
   logic                 w_clear;
   logic [NUM_LANES-1:0] w_rise;
   logic [NUM_LANES-1:0] w_hit_v;
   logic [NUM_LANES-1:0] w_miss_v;
   logic [NUM_LANES-1:0] w_seen_all;
   logic [2:0]           w_nh;
   logic [2:0]           w_nm;
   logic                 w_any_event;
   logic                 w_any_miss;
   logic                 w_bonus;
   logic [3:0]           w_addend;
   logic [15:0]          w_score_sum;
   logic [8:0]           w_hits_sum;
   logic [8:0]           w_misses_sum;
   logic [8:0]           w_combo_sum;
   logic [7:0]           w_hits_nxt;
   logic [7:0]           w_misses_nxt;
   logic [7:0]           w_combo_nxt;
   logic [3:0]           w_timer_nxt;
   logic                 w_fh_nxt;
   logic                 w_fm_nxt;

   // A lane event is a done rise; score_lvl in the same frame decides hit or miss.
   assign w_rise      = bus.done_lvl & ~r_prev_done;
   assign w_hit_v     = w_rise & bus.score_lvl;
   assign w_miss_v    = w_rise & ~bus.score_lvl;
   assign w_nh        = popcount4(w_hit_v);
   assign w_nm        = popcount4(w_miss_v);
   assign w_any_event = |w_rise;
   assign w_any_miss  = |w_miss_v;
   assign w_seen_all  = r_done_seen | w_rise;

   // Bonus is judged on the combo held before this frame's events.
   assign w_bonus  = (r_combo >= 8'(BONUS_AT));
   assign w_addend = w_bonus ? {w_nh, 1'b0} : {1'b0, w_nh};

   assign w_hits_sum   = {1'b0, r_hits}   + {6'd0, w_nh};
   assign w_misses_sum = {1'b0, r_misses} + {6'd0, w_nm};
   assign w_combo_sum  = {1'b0, r_combo}  + {6'd0, w_nh};
   assign w_hits_nxt   = w_hits_sum[8]   ? 8'hff : w_hits_sum[7:0];
   assign w_misses_nxt = w_misses_sum[8] ? 8'hff : w_misses_sum[7:0];
   assign w_combo_nxt  = w_any_miss ? 8'd0 : (w_combo_sum[8] ? 8'hff : w_combo_sum[7:0]);

   bcd_add_sat u_bcd_add (
      .i_bcd    (r_score),
      .i_addend (w_addend),
      .o_bcd    (w_score_sum)
   );

   // State register.
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state plus the clear/process strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_process   = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.keycode == KEY_START) begin
               w_clear     = 1'b1;
               w_state_nxt = PLAY;
            end
         end
         PLAY: begin
            w_process = 1'b1;
            if (bus.keycode == KEY_CLEAR)  w_state_nxt = IDLE;
            else if (&w_seen_all)          w_state_nxt = OVER;
         end
         OVER: begin
            if (bus.keycode == KEY_CLEAR) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Flash timer: a new event reloads it, otherwise it runs down in every state.
   always_comb begin
      w_timer_nxt = r_flash_timer;
      w_fh_nxt    = r_flash_hit;
      w_fm_nxt    = r_flash_miss;
      if (w_clear) begin
         w_timer_nxt = 4'd0;
         w_fh_nxt    = 1'b0;
         w_fm_nxt    = 1'b0;
      end else if (w_process && w_any_event) begin
         w_timer_nxt = FLASH_FRAMES;
         w_fm_nxt    = w_any_miss;
         w_fh_nxt    = ~w_any_miss;
      end else if (r_flash_timer != 4'd0) begin
         w_timer_nxt = r_flash_timer - 4'd1;
         if (r_flash_timer == 4'd1) begin
            w_fh_nxt = 1'b0;
            w_fm_nxt = 1'b0;
         end
      end
   end

   // Score, combo, counts and edge history; counters only move while playing.
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_prev_score  <= '0;
         r_prev_done   <= '0;
         r_done_seen   <= '0;
         r_score       <= 16'd0;
         r_combo       <= 8'd0;
         r_max_combo   <= 8'd0;
         r_hits        <= 8'd0;
         r_misses      <= 8'd0;
         r_flash_timer <= 4'd0;
         r_flash_hit   <= 1'b0;
         r_flash_miss  <= 1'b0;
      end else begin
         r_prev_score  <= bus.score_lvl;
         r_prev_done   <= bus.done_lvl;
         r_flash_timer <= w_timer_nxt;
         r_flash_hit   <= w_fh_nxt;
         r_flash_miss  <= w_fm_nxt;
         if (w_clear) begin
            r_done_seen <= '0;
            r_score     <= 16'd0;
            r_combo     <= 8'd0;
            r_max_combo <= 8'd0;
            r_hits      <= 8'd0;
            r_misses    <= 8'd0;
         end else if (w_process) begin
            r_done_seen <= w_seen_all;
            r_score     <= w_score_sum;
            r_combo     <= w_combo_nxt;
            r_hits      <= w_hits_nxt;
            r_misses    <= w_misses_nxt;
            if (w_combo_nxt > r_max_combo) r_max_combo <= w_combo_nxt;
         end
      end
   end

   assign bus.score_bcd  = r_score;
   assign bus.combo      = r_combo;
   assign bus.max_combo  = r_max_combo;
   assign bus.hits       = r_hits;
   assign bus.misses     = r_misses;
   assign bus.flash_hit  = r_flash_hit;
   assign bus.flash_miss = r_flash_miss;
   assign bus.playing    = (r_state == PLAY);
   assign bus.game_over  = (r_state == OVER);

   assign o_dbg.state       = r_state;
   assign o_dbg.done_seen   = r_done_seen;
   assign o_dbg.prev_done   = r_prev_done;
   assign o_dbg.prev_score  = r_prev_score;
   assign o_dbg.flash_timer = r_flash_timer;

endmodule

// File: tb/tb_score_tally.sv
// tb_score_tally: directed scenarios plus random frames against a rule-level game model.
module tb_score_tally;
   import tally_pkg::*;

   logic frame_clk = 1'b0;
   logic Reset_n;
   dbg_t w_dbg;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [15:0] exp_q[$];

   score_tally_if bus();

   score_tally dut (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .bus       (bus),
      .o_dbg     (w_dbg)
   );

   // Clock.
   always #5 frame_clk = ~frame_clk;

   // ---------------- reference model (game rules, plain integers) ----------------
   int   m_score, m_combo, m_max, m_hits, m_misses, m_timer;
   bit   m_fh, m_fm, m_in_round, m_over;
   logic [3:0] m_prev_done, m_seen;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_score = 0; m_combo = 0; m_max = 0; m_hits = 0; m_misses = 0; m_timer = 0;
      m_fh = 0; m_fm = 0; m_in_round = 0; m_over = 0; m_prev_done = '0; m_seen = '0;
   endtask

   task automatic flash_tick();
      if (m_timer > 0) begin
         m_timer--;
         if (m_timer == 0) begin m_fh = 0; m_fm = 0; end
      end
   endtask

   task automatic model_step(input logic [7:0] kc, input logic [3:0] sl, input logic [3:0] dl);
      int nh, nm, pts;
      logic [3:0] ev;
      nh = 0; nm = 0; ev = '0;
      for (int i = 0; i < 4; i++) begin
         if (dl[i] && !m_prev_done[i]) begin
            ev[i] = 1'b1;
            if (sl[i]) nh++; else nm++;
         end
      end
      if (m_in_round) begin
         pts      = nh * ((m_combo >= 10) ? 2 : 1);
         m_score  = (m_score + pts > 9999) ? 9999 : m_score + pts;
         m_hits   = (m_hits + nh > 255) ? 255 : m_hits + nh;
         m_misses = (m_misses + nm > 255) ? 255 : m_misses + nm;
         m_combo  = (nm > 0) ? 0 : ((m_combo + nh > 255) ? 255 : m_combo + nh);
         if (m_combo > m_max) m_max = m_combo;
         m_seen = m_seen | ev;
         if (ev != 0) begin m_timer = 15; m_fm = (nm > 0); m_fh = (nm == 0); end
         else flash_tick();
         if (kc == KEY_CLEAR) m_in_round = 0;
         else if (m_seen == 4'hf) begin m_in_round = 0; m_over = 1; end
      end else if (m_over) begin
         flash_tick();
         if (kc == KEY_CLEAR) m_over = 0;
      end else if (kc == KEY_START) begin
         m_score = 0; m_combo = 0; m_max = 0; m_hits = 0; m_misses = 0;
         m_timer = 0; m_fh = 0; m_fm = 0; m_seen = '0; m_in_round = 1;
      end else begin
         flash_tick();
      end
      m_prev_done = dl;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic [7:0] kc, input logic [3:0] sl, input logic [3:0] dl);
      @(negedge frame_clk);
      bus.keycode   = kc;
      bus.score_lvl = sl;
      bus.done_lvl  = dl;
      model_step(kc, sl, dl);
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_hit(input int lane);
      step(8'h00, 4'(1 << lane), 4'(1 << lane));
      step(8'h00, 4'h0, 4'h0);
   endtask

   task automatic do_miss(input int lane);
      step(8'h00, 4'h0, 4'(1 << lane));
      step(8'h00, 4'h0, 4'h0);
   endtask

   task automatic new_round();
      step(KEY_CLEAR, 4'h0, 4'h0);
      step(KEY_START, 4'h0, 4'h0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      Reset_n = 1'b0;
      bus.keycode = 8'h00; bus.score_lvl = 4'h0; bus.done_lvl = 4'h0;
      model_reset();
      #12;
      n_tests++; if (bus.score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset score got %h exp 0000", bus.score_bcd); end
      n_tests++; if ({bus.combo, bus.max_combo, bus.hits, bus.misses} !== 32'd0) begin n_fail++; $display("FAIL reset counters got %h exp 0", {bus.combo, bus.max_combo, bus.hits, bus.misses}); end
      n_tests++; if ({bus.flash_hit, bus.flash_miss, bus.playing, bus.game_over} !== 4'b0000) begin n_fail++; $display("FAIL reset flags got %b exp 0000", {bus.flash_hit, bus.flash_miss, bus.playing, bus.game_over}); end
      n_tests++; if (w_dbg.state !== IDLE) begin n_fail++; $display("FAIL reset state got %0d exp %0d", w_dbg.state, IDLE); end
      @(negedge frame_clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_single_hit();
      new_round();
      n_tests++; if (bus.playing !== 1'b1) begin n_fail++; $display("FAIL start playing got %b exp 1", bus.playing); end
      step(8'h00, 4'b0001, 4'b0001);
      n_tests++; if (bus.score_bcd !== 16'h0001) begin n_fail++; $display("FAIL single score got %h exp 0001", bus.score_bcd); end
      n_tests++; if (bus.combo !== 8'd1) begin n_fail++; $display("FAIL single combo got %0d exp 1", bus.combo); end
      n_tests++; if (bus.hits !== 8'd1) begin n_fail++; $display("FAIL single hits got %0d exp 1", bus.hits); end
      n_tests++; if ({bus.flash_hit, bus.flash_miss} !== 2'b10) begin n_fail++; $display("FAIL single flash got %b exp 10", {bus.flash_hit, bus.flash_miss}); end
      step(8'h00, 4'h0, 4'h0);
   endtask

   task automatic test_miss_combo();
      new_round();
      for (int i = 0; i < 3; i++) do_hit(0);
      step(8'h00, 4'h0, 4'b0100);
      n_tests++; if (bus.combo !== 8'd0) begin n_fail++; $display("FAIL miss combo got %0d exp 0", bus.combo); end
      n_tests++; if (bus.max_combo !== 8'd3) begin n_fail++; $display("FAIL miss max_combo got %0d exp 3", bus.max_combo); end
      n_tests++; if (bus.misses !== 8'd1) begin n_fail++; $display("FAIL miss misses got %0d exp 1", bus.misses); end
      n_tests++; if ({bus.flash_hit, bus.flash_miss} !== 2'b01) begin n_fail++; $display("FAIL miss flash got %b exp 01", {bus.flash_hit, bus.flash_miss}); end
      for (int i = 0; i < 14; i++) step(8'h00, 4'h0, 4'h0);
      n_tests++; if (bus.flash_miss !== 1'b1) begin n_fail++; $display("FAIL flash_hold14 got %b exp 1", bus.flash_miss); end
      step(8'h00, 4'h0, 4'h0);
      n_tests++; if (bus.flash_miss !== 1'b0) begin n_fail++; $display("FAIL flash_clear15 got %b exp 0", bus.flash_miss); end
   endtask

   task automatic test_bonus();
      new_round();
      for (int i = 0; i < 9; i++) do_hit(0);
      step(8'h00, 4'b0011, 4'b0011);
      n_tests++; if (bus.score_bcd !== 16'h0011) begin n_fail++; $display("FAIL bonus_pair score got %h exp 0011", bus.score_bcd); end
      n_tests++; if (bus.combo !== 8'd11) begin n_fail++; $display("FAIL bonus_pair combo got %0d exp 11", bus.combo); end
      step(8'h00, 4'h0, 4'h0);
      do_hit(0);
      n_tests++; if (bus.score_bcd !== 16'h0013) begin n_fail++; $display("FAIL bonus_single score got %h exp 0013", bus.score_bcd); end
      step(8'h00, 4'b0001, 4'b0011);
      n_tests++; if (bus.combo !== 8'd0) begin n_fail++; $display("FAIL hitmiss combo got %0d exp 0", bus.combo); end
      n_tests++; if ({bus.hits, bus.misses} !== {8'd13, 8'd1}) begin n_fail++; $display("FAIL hitmiss counts got %0d/%0d exp 13/1", bus.hits, bus.misses); end
      n_tests++; if (bus.score_bcd !== to_bcd(m_score)) begin n_fail++; $display("FAIL hitmiss score got %h exp %h", bus.score_bcd, to_bcd(m_score)); end
      n_tests++; if ({bus.flash_hit, bus.flash_miss} !== 2'b01) begin n_fail++; $display("FAIL hitmiss flash got %b exp 01", {bus.flash_hit, bus.flash_miss}); end
      step(8'h00, 4'h0, 4'h0);
   endtask

   task automatic test_bcd_carry();
      new_round();
      while (m_score < 99) begin
         if (m_combo >= 10 && m_score + 2 > 99) do_miss(0); else do_hit(0);
      end
      n_tests++; if (bus.score_bcd !== 16'h0099) begin n_fail++; $display("FAIL carry pre got %h exp 0099", bus.score_bcd); end
      do_miss(0);
      do_hit(0);
      n_tests++; if (bus.score_bcd !== 16'h0100) begin n_fail++; $display("FAIL carry got %h exp 0100", bus.score_bcd); end
      do_miss(0);
      while (m_score < 9998) begin
         if (m_combo >= 10 && m_score + 2 > 9998) do_miss(0); else do_hit(0);
      end
      n_tests++; if (bus.score_bcd !== 16'h9998) begin n_fail++; $display("FAIL sat pre got %h exp 9998", bus.score_bcd); end
      n_tests++; if ({bus.hits, bus.combo} !== {8'd255, 8'd255}) begin n_fail++; $display("FAIL sat counts got %0d/%0d exp 255/255", bus.hits, bus.combo); end
      step(8'h00, 4'b0011, 4'b0011);
      n_tests++; if (bus.score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat got %h exp 9999", bus.score_bcd); end
      step(8'h00, 4'h0, 4'h0);
      do_hit(0);
      n_tests++; if (bus.score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat hold got %h exp 9999", bus.score_bcd); end
      n_tests++; if (bus.playing !== 1'b1) begin n_fail++; $display("FAIL sat playing got %b exp 1", bus.playing); end
   endtask

   task automatic test_round_end();
      new_round();
      step(8'h00, 4'b0001, 4'b0001);
      step(8'h00, 4'b0001, 4'b0011);
      step(8'h00, 4'b0101, 4'b0111);
      n_tests++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL end early game_over got %b exp 0", bus.game_over); end
      step(8'h00, 4'b1101, 4'b1111);
      n_tests++; if ({bus.game_over, bus.playing} !== 2'b10) begin n_fail++; $display("FAIL end flags got %b exp 10", {bus.game_over, bus.playing}); end
      n_tests++; if ({bus.hits, bus.misses, bus.combo} !== {8'd3, 8'd1, 8'd2}) begin n_fail++; $display("FAIL end counts got %0d/%0d/%0d exp 3/1/2", bus.hits, bus.misses, bus.combo); end
      n_tests++; if (bus.score_bcd !== 16'h0003) begin n_fail++; $display("FAIL end score got %h exp 0003", bus.score_bcd); end
      step(8'h00, 4'h0, 4'h0);
      step(8'h00, 4'hf, 4'hf);
      n_tests++; if ({bus.hits, bus.misses, bus.score_bcd} !== {8'd3, 8'd1, 16'h0003}) begin n_fail++; $display("FAIL frozen got %0d/%0d/%h exp 3/1/0003", bus.hits, bus.misses, bus.score_bcd); end
      n_tests++; if (bus.flash_hit !== m_fh) begin n_fail++; $display("FAIL over flash got %b exp %b", bus.flash_hit, m_fh); end
      step(KEY_CLEAR, 4'hf, 4'hf);
      n_tests++; if ({bus.playing, bus.game_over, bus.hits} !== {2'b00, 8'd3}) begin n_fail++; $display("FAIL clear got %b%b/%0d exp 00/3", bus.playing, bus.game_over, bus.hits); end
      step(KEY_START, 4'hf, 4'hf);
      n_tests++; if ({bus.playing, bus.hits, bus.misses, bus.score_bcd} !== {1'b1, 8'd0, 8'd0, 16'h0000}) begin n_fail++; $display("FAIL restart got %b/%0d/%0d/%h exp 1/0/0/0000", bus.playing, bus.hits, bus.misses, bus.score_bcd); end
      step(8'h00, 4'h0, 4'h0);
   endtask

   task automatic test_stale_and_reset();
      step(KEY_CLEAR, 4'h0, 4'h0);
      step(8'h00, 4'h0, 4'b0010);
      step(KEY_START, 4'h0, 4'b0010);
      for (int i = 0; i < 3; i++) step(8'h00, 4'b0010, 4'b0010);
      n_tests++; if ({bus.hits, bus.misses, bus.flash_hit} !== {8'd0, 8'd0, 1'b0}) begin n_fail++; $display("FAIL stale got %0d/%0d/%b exp 0/0/0", bus.hits, bus.misses, bus.flash_hit); end
      step(8'h00, 4'h0, 4'h0);
      step(8'h00, 4'b0010, 4'b0010);
      n_tests++; if (bus.hits !== 8'd1) begin n_fail++; $display("FAIL fresh_edge hits got %0d exp 1", bus.hits); end
      #2;
      Reset_n = 1'b0;
      #1;
      n_tests++; if ({bus.score_bcd, bus.combo, bus.max_combo, bus.hits, bus.misses} !== 48'd0) begin n_fail++; $display("FAIL midreset counters got %h exp 0", {bus.score_bcd, bus.combo, bus.hits}); end
      n_tests++; if ({bus.flash_hit, bus.flash_miss, bus.playing, bus.game_over} !== 4'b0000) begin n_fail++; $display("FAIL midreset flags got %b exp 0000", {bus.flash_hit, bus.flash_miss, bus.playing, bus.game_over}); end
      bus.keycode = 8'h00; bus.score_lvl = 4'h0; bus.done_lvl = 4'h0;
      model_reset();
      @(posedge frame_clk);
      @(negedge frame_clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] kc;
      logic [3:0] sl, dl;
      int r;
      new_round();
      for (int n = 0; n < 400; n++) begin
         r  = $urandom_range(0, 39);
         kc = (r == 0) ? KEY_START : (r == 1) ? KEY_CLEAR : 8'($urandom_range(4, 31));
         sl = 4'($urandom_range(0, 15));
         dl = 4'($urandom_range(0, 15));
         step(kc, sl, dl);
         exp_q.push_back(to_bcd(m_score));
         n_tests++; if (bus.score_bcd !== exp_q.pop_front()) begin n_fail++; $display("FAIL rnd%0d score got %h exp %h", n, bus.score_bcd, to_bcd(m_score)); end
         n_tests++; if ({bus.combo, bus.max_combo} !== {8'(m_combo), 8'(m_max)}) begin n_fail++; $display("FAIL rnd%0d combo got %0d/%0d exp %0d/%0d", n, bus.combo, bus.max_combo, m_combo, m_max); end
         n_tests++; if ({bus.hits, bus.misses} !== {8'(m_hits), 8'(m_misses)}) begin n_fail++; $display("FAIL rnd%0d counts got %0d/%0d exp %0d/%0d", n, bus.hits, bus.misses, m_hits, m_misses); end
         n_tests++; if ({bus.flash_hit, bus.flash_miss} !== {m_fh, m_fm}) begin n_fail++; $display("FAIL rnd%0d flash got %b%b exp %b%b", n, bus.flash_hit, bus.flash_miss, m_fh, m_fm); end
         n_tests++; if ({bus.playing, bus.game_over} !== {m_in_round, m_over}) begin n_fail++; $display("FAIL rnd%0d phase got %b%b exp %b%b", n, bus.playing, bus.game_over, m_in_round, m_over); end
      end
   endtask

   // Sequence and report.
   initial begin
      test_reset();
      test_single_hit();
      test_miss_combo();
      test_bonus();
      test_bcd_carry();
      test_round_end();
      test_stale_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
